fetch_redirect_unit: RTL and testbench

//  Owns the architectural PC and the instruction-memory request side of the fetch stage.

---
 rtl/fetch_redirect_unit_pkg.sv | 20 ++
 rtl/fetch_redirect_unit_sel.sv | 43 ++++
 rtl/fetch_redirect_unit.sv | 138 +++++++++++++
 tb/tb_fetch_redirect_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage definitions: FSM encodings,
// reset PC default and redirect-source codes.
package fetch_redirect_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_PEND
  } fsm_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_TRAP,
    SRC_MRET,
    SRC_BRANCH
  } redir_src_e;

endpackage

// File: rtl/fetch_redirect_unit_sel.sv
// Redirect priority mux with target alignment check.
// Trap beats mret beats branch.
module fetch_redirect_unit_sel
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              mret_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  logic              branch_i,
  input  logic              jalr_i,
  input  logic [ADDR_W-1:0] target_i,
  output redir_src_e        src_o,
  output logic [ADDR_W-1:0] tgt_o,
  output logic              misaligned_o
);

  always_comb begin
    src_o = SRC_NONE;
    tgt_o = '0;
    priority case (1'b1)
      trap_i: begin
        src_o = SRC_TRAP;
        tgt_o = {trap_vec_i[ADDR_W-1:2], 2'b00};
      end
      mret_i: begin
        src_o = SRC_MRET;
        tgt_o = {epc_i[ADDR_W-1:2], 2'b00};
      end
      branch_i: begin
        src_o = SRC_BRANCH;
        tgt_o = jalr_i ? {target_i[ADDR_W-1:1], 1'b0}
                       : target_i;
      end
      default: ;
    endcase
    misaligned_o = (src_o == SRC_BRANCH)
                && (tgt_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: imem request side, redirect
// handling with deferral across wait states.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              branch_taken_in,
  input  logic              jalr_in,
  input  logic [ADDR_W-1:0] target_addr_in,
  input  logic              trap_taken_in,
  input  logic [ADDR_W-1:0] trap_vector_in,
  input  logic              mret_in,
  input  logic [ADDR_W-1:0] epc_in,
  input  logic              stall_in,
  input  logic              imem_ready_in,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4_out,
  output logic              instr_valid_out,
  output logic              flush_out,
  output logic              misaligned_instr_out,
  output logic [ADDR_W-1:0] misaligned_addr_out
);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              flush_q, flush_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;

  redir_src_e        src;
  logic [ADDR_W-1:0] tgt;
  logic              misaligned;
  logic              redir_ok;
  logic              valid;

  fetch_redirect_unit_sel #(
    .ADDR_W(ADDR_W)
  ) u_sel (
    .trap_i      (trap_taken_in),
    .trap_vec_i  (trap_vector_in),
    .mret_i      (mret_in),
    .epc_i       (epc_in),
    .branch_i    (branch_taken_in),
    .jalr_i      (jalr_in),
    .target_i    (target_addr_in),
    .src_o       (src),
    .tgt_o       (tgt),
    .misaligned_o(misaligned)
  );

  assign redir_ok = (src != SRC_NONE) && !misaligned;

  // Advance only on a consumed fetch so the
  // flushed slot refetches the redirect target.
  assign valid = (state_q == ST_RUN)
              && imem_ready_in
              && (src == SRC_NONE)
              && !flush_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;
    mis_addr_d = '0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redir_ok) begin
          flush_d = 1'b1;
          if (imem_ready_in) begin
            pc_d = tgt;
          end else begin
            pend_pc_d = tgt;
            state_d   = ST_PEND;
          end
        end else if (valid && !stall_in) begin
          pc_d = pc_q + ADDR_W'(4);
        end
      end
      ST_PEND: begin
        if (redir_ok) begin
          pend_pc_d = tgt;
          flush_d   = 1'b1;
          if (imem_ready_in) begin
            pc_d    = tgt;
            state_d = ST_RUN;
          end
        end else if (imem_ready_in) begin
          pc_d    = pend_pc_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (state_q != ST_BOOT && misaligned) begin
      mis_d      = 1'b1;
      mis_addr_d = tgt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign imem_req_out         = (state_q != ST_BOOT);
  assign imem_addr_out        = pc_q;
  assign pc_out               = pc_q;
  assign pc_plus4_out         = pc_q + ADDR_W'(4);
  assign instr_valid_out      = valid;
  assign flush_out            = flush_q;
  assign misaligned_instr_out = mis_q;
  assign misaligned_addr_out  = mis_addr_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit.
// Inputs change 1ns after posedge; checks follow.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic        jalr;
  logic [31:0] target_addr;
  logic        trap_taken;
  logic [31:0] trap_vector;
  logic        mret;
  logic [31:0] epc;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        flush;
  logic        mis;
  logic [31:0] mis_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .branch_taken_in     (branch_taken),
    .jalr_in             (jalr),
    .target_addr_in      (target_addr),
    .trap_taken_in       (trap_taken),
    .trap_vector_in      (trap_vector),
    .mret_in             (mret),
    .epc_in              (epc),
    .stall_in            (stall),
    .imem_ready_in       (imem_ready),
    .imem_req_out        (imem_req),
    .imem_addr_out       (imem_addr),
    .pc_out              (pc),
    .pc_plus4_out        (pc_plus4),
    .instr_valid_out     (instr_valid),
    .flush_out           (flush),
    .misaligned_instr_out(mis),
    .misaligned_addr_out (mis_addr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    branch_taken = 1'b0;
    jalr         = 1'b0;
    trap_taken   = 1'b0;
    mret         = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    target_addr = '0;
    trap_vector = '0;
    epc         = '0;
    stall       = 1'b0;
    imem_ready  = 1'b1;
    #12;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_misaddr", mis_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_req", 32'(imem_req), 32'd0);
    step();
    chk("run_req", 32'(imem_req), 32'd1);
    chk("seq_a0", imem_addr, 32'h0);
    chk("seq_v0", 32'(instr_valid), 32'd1);
    step();
    chk("seq_a4", imem_addr, 32'h4);
    chk("seq_v4", 32'(instr_valid), 32'd1);
    step();
    chk("seq_a8", imem_addr, 32'h8);
    chk("seq_v8", 32'(instr_valid), 32'd1);
    chk("pc_plus4", pc_plus4, 32'hC);

    branch_taken = 1'b1;
    target_addr  = 32'h100;
    #1;
    chk("br_kill", 32'(instr_valid), 32'd0);
    step();
    clr();
    #1;
    chk("br_addr", imem_addr, 32'h100);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_fvalid", 32'(instr_valid), 32'd0);
    step();
    chk("br_flush1", 32'(flush), 32'd0);
    chk("br_v100", 32'(instr_valid), 32'd1);
    step();
    chk("br_a104", imem_addr, 32'h104);

    branch_taken = 1'b1;
    target_addr  = 32'h200;
    imem_ready   = 1'b0;
    step();
    clr();
    #1;
    chk("pd_addr0", imem_addr, 32'h104);
    chk("pd_flush", 32'(flush), 32'd1);
    chk("pd_v0", 32'(instr_valid), 32'd0);
    step();
    chk("pd_addr1", imem_addr, 32'h104);
    chk("pd_flush1", 32'(flush), 32'd0);
    imem_ready = 1'b1;
    #1;
    chk("pd_discard", 32'(instr_valid), 32'd0);
    step();
    chk("pd_a200", imem_addr, 32'h200);
    chk("pd_v200", 32'(instr_valid), 32'd1);

    trap_taken   = 1'b1;
    trap_vector  = 32'h81;
    branch_taken = 1'b1;
    target_addr  = 32'h300;
    step();
    clr();
    #1;
    chk("trap_addr", imem_addr, 32'h80);
    chk("trap_flush", 32'(flush), 32'd1);
    step();
    mret = 1'b1;
    epc  = 32'h106;
    step();
    clr();
    #1;
    chk("mret_addr", imem_addr, 32'h104);
    step();

    branch_taken = 1'b1;
    jalr         = 1'b1;
    target_addr  = 32'h103;
    step();
    clr();
    #1;
    chk("jalr_mis", 32'(mis), 32'd1);
    chk("jalr_maddr", mis_addr, 32'h102);
    chk("jalr_hold", pc, 32'h104);
    chk("jalr_noflush", 32'(flush), 32'd0);
    step();
    chk("jalr_mis1", 32'(mis), 32'd0);
    chk("jalr_adv", pc, 32'h108);

    trap_taken   = 1'b1;
    trap_vector  = 32'h40;
    branch_taken = 1'b1;
    target_addr  = 32'h102;
    step();
    clr();
    #1;
    chk("trapmis_flag", 32'(mis), 32'd0);
    chk("trapmis_pc", pc, 32'h40);
    step();
    stall = 1'b1;
    step();
    chk("stall_pc1", pc, 32'h40);
    step();
    chk("stall_pc2", pc, 32'h40);
    stall = 1'b0;
    step();
    chk("stall_rel", pc, 32'h44);

    branch_taken = 1'b1;
    target_addr  = 32'hFFFF_FFFC;
    step();
    clr();
    #1;
    chk("wrap_p4", pc_plus4, 32'h0);
    step();
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_mis", 32'(mis), 32'd0);

    branch_taken = 1'b1;
    target_addr  = 32'h500;
    imem_ready   = 1'b0;
    step();
    clr();
    #1;
    chk("mid_flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
